// File: rtl/spi_slave_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_gen
// Purpose  : Generic SPI slave. Oversamples the SPI pins with the system clock,
//            shifts DATA_W-bit words in on mosi and out on miso, and exchanges
//            whole words with the host side through valid/ready handshakes.
//            Several words may be carried back-to-back under one cs assertion.
// Ports    : clk, rst              - system clock, synchronous active-high reset
//            sclk, cs, mosi        - asynchronous SPI pins (cs active-low)
//            miso                  - serial data out (0 while cs is high)
//            rx_data/valid/ready   - received word stream (held until taken)
//            tx_data/valid/ready   - word to send, 1-entry buffer
//            busy                  - synchronised cs is asserted
//            frame_err             - 1-cycle pulse: cs rose with a partial word
//            rx_overrun            - 1-cycle pulse: unread rx word overwritten
//            tx_underrun           - 1-cycle pulse: TX_IDLE sent, buffer empty
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_gen #(
  parameter int                DATA_W    = 8,
  parameter int                CPOL      = 0,
  parameter int                CPHA      = 0,
  parameter int                LSB_FIRST = 0,
  parameter logic [DATA_W-1:0] TX_IDLE   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              rx_overrun,
  output logic              tx_underrun
);

  localparam int                 C_CNT_W     = $clog2(DATA_W);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST  = C_CNT_W'(DATA_W - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
  localparam logic               C_SCLK_IDLE = (CPOL != 0);

  // --------------------------------------------------------------------------
  // Pin synchronisers. The third sclk/cs flop holds the previous synchronised
  // value so edges are seen for exactly one clk cycle.
  // --------------------------------------------------------------------------
  logic sclk_s1_q, sclk_s2_q, sclk_d3_q;
  logic cs_s1_q, cs_s2_q, cs_d3_q;
  logic mosi_s1_q, mosi_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1_q <= C_SCLK_IDLE;
      sclk_s2_q <= C_SCLK_IDLE;
      sclk_d3_q <= C_SCLK_IDLE;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_d3_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_d3_q <= sclk_s2_q;
      cs_s1_q   <= cs;
      cs_s2_q   <= cs_s1_q;
      cs_d3_q   <= cs_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Edge classification
  // --------------------------------------------------------------------------
  logic w_sclk_rise, w_sclk_fall;
  logic w_lead, w_trail;
  logic w_sample, w_shift;
  logic w_active, w_cs_fall, w_cs_rise;

  assign w_sclk_rise = sclk_s2_q & ~sclk_d3_q;
  assign w_sclk_fall = ~sclk_s2_q & sclk_d3_q;
  assign w_lead      = (CPOL != 0) ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = (CPOL != 0) ? w_sclk_rise : w_sclk_fall;
  assign w_sample    = (CPHA != 0) ? w_trail : w_lead;
  assign w_shift     = (CPHA != 0) ? w_lead : w_trail;
  assign w_active    = ~cs_s2_q;
  assign w_cs_fall   = ~cs_s2_q & cs_d3_q;
  assign w_cs_rise   = cs_s2_q & ~cs_d3_q;

  // --------------------------------------------------------------------------
  // Bit-order helpers: the transmit register always keeps the next bit to be
  // presented at the end selected by LSB_FIRST.
  // --------------------------------------------------------------------------
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               wrap_q, wrap_d;        // word done, next shift edge loads
  logic [DATA_W-1:0]  rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]  tx_sr_q, tx_sr_d;
  logic               miso_q, miso_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]  txbuf_q, txbuf_d;
  logic               txfull_q, txfull_d;
  logic               frame_err_q, frame_err_d;
  logic               rx_overrun_q, rx_overrun_d;
  logic               tx_underrun_q, tx_underrun_d;

  logic               w_tx_hs;
  logic               w_load;
  logic [DATA_W-1:0]  w_load_word;
  logic [DATA_W-1:0]  w_rx_next;

  assign w_tx_hs = tx_valid & ~txfull_q;

  // A word load happens at the start of a frame and at every word boundary
  // inside a frame. An incoming tx word may bypass the empty buffer.
  assign w_load      = w_active & (w_cs_fall | (w_shift & wrap_q));
  assign w_load_word = txfull_q ? txbuf_q : (w_tx_hs ? tx_data : TX_IDLE);

  assign w_rx_next = (LSB_FIRST != 0) ? {mosi_s2_q, rx_sr_q[DATA_W-1:1]}
                                      : {rx_sr_q[DATA_W-2:0], mosi_s2_q};

  always_comb begin
    cnt_d         = cnt_q;
    wrap_d        = wrap_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    miso_d        = miso_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    txbuf_d       = txbuf_q;
    txfull_d      = txfull_q;
    frame_err_d   = 1'b0;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;

    // Receive handshake; a word completing this cycle overrides the clear.
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    // Transmit buffer
    if (w_tx_hs) begin
      txbuf_d  = tx_data;
      txfull_d = 1'b1;
    end
    if (w_load) begin
      txfull_d      = 1'b0;
      tx_underrun_d = ~txfull_q & ~w_tx_hs;
    end

    if (!w_active) begin
      // Deselected: ignore sclk/mosi. A nonzero count means cs rose mid-word.
      cnt_d       = '0;
      wrap_d      = 1'b0;
      miso_d      = 1'b0;
      frame_err_d = w_cs_rise & (cnt_q != '0);
    end else if (w_cs_fall) begin
      cnt_d  = '0;
      wrap_d = 1'b0;
      if (CPHA != 0) begin
        // First bit goes out on the first leading edge.
        tx_sr_d = w_load_word;
        miso_d  = 1'b0;
      end else begin
        miso_d  = first_bit(w_load_word);
        tx_sr_d = advance(w_load_word);
      end
    end else begin
      if (w_sample) begin
        rx_sr_d = w_rx_next;
        if (cnt_q == C_CNT_LAST) begin
          cnt_d        = '0;
          wrap_d       = 1'b1;
          rx_data_d    = w_rx_next;
          rx_valid_d   = 1'b1;
          rx_overrun_d = rx_valid_q & ~rx_ready;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      if (w_shift) begin
        if (wrap_q) begin
          // Word boundary: present the first bit of the next word.
          wrap_d  = 1'b0;
          miso_d  = first_bit(w_load_word);
          tx_sr_d = advance(w_load_word);
        end else begin
          miso_d  = first_bit(tx_sr_q);
          tx_sr_d = advance(tx_sr_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      wrap_q        <= 1'b0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      miso_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      txbuf_q       <= '0;
      txfull_q      <= 1'b0;
      frame_err_q   <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      wrap_q        <= wrap_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      miso_q        <= miso_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      txbuf_q       <= txbuf_d;
      txfull_q      <= txfull_d;
      frame_err_q   <= frame_err_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. miso is gated so it drops in the same cycle cs is seen high.
  // --------------------------------------------------------------------------
  assign miso        = miso_q & ~cs_s2_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = ~txfull_q;
  assign busy        = ~cs_s2_q;
  assign frame_err   = frame_err_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_gen
// Purpose  : Self-checking bench for spi_slave_gen. Instance A: 8-bit mode 0
//            MSB first. Instance B: 16-bit CPOL=1 CPHA=1 LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst;

  // Instance A
  logic       sclk_a, cs_a, mosi_a, miso_a;
  logic [7:0] rx_data_a, tx_data_a;
  logic       rx_valid_a, rx_ready_a, tx_valid_a, tx_ready_a;
  logic       busy_a, ferr_a, ovr_a, und_a;

  // Instance B
  logic        sclk_b, cs_b, mosi_b, miso_b;
  logic [15:0] rx_data_b, tx_data_b;
  logic        rx_valid_b, rx_ready_b, tx_valid_b, tx_ready_b;
  logic        busy_b, ferr_b, ovr_b, und_b;

  spi_slave_gen #(.DATA_W(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .TX_IDLE(8'h00)) u_a (
    .clk(clk), .rst(rst), .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a), .miso(miso_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .busy(busy_a), .frame_err(ferr_a), .rx_overrun(ovr_a), .tx_underrun(und_a)
  );

  spi_slave_gen #(.DATA_W(16), .CPOL(1), .CPHA(1), .LSB_FIRST(1), .TX_IDLE(16'h0000)) u_b (
    .clk(clk), .rst(rst), .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b), .miso(miso_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .busy(busy_b), .frame_err(ferr_b), .rx_overrun(ovr_b), .tx_underrun(und_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_ferr_a = 0, n_ovr_a = 0, n_und_a = 0;
  int n_ferr_b = 0, n_und_b = 0;
  logic [7:0]  q_a[$];
  logic [15:0] q_b[$];

  // Pulse counters and received-word capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (ferr_a) n_ferr_a++;
      if (ovr_a)  n_ovr_a++;
      if (und_a)  n_und_a++;
      if (ferr_b) n_ferr_b++;
      if (und_b)  n_und_b++;
      if (rx_valid_a && rx_ready_a) q_a.push_back(rx_data_a);
      if (rx_valid_b && rx_ready_b) q_b.push_back(rx_data_b);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] qa_at(input int idx);
    return (q_a.size() > idx) ? 32'(q_a[idx]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] qb_at(input int idx);
    return (q_b.size() > idx) ? 32'(q_b[idx]) : 32'hDEAD_BEEF;
  endfunction

  // One sclk half-period (>= 62 ns), ending on a falling clk edge.
  task automatic half();
    #62;
    @(negedge clk);
  endtask

  task automatic push_a(input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (!tx_ready_a && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("push_a_ready", 32'(tx_ready_a), 32'h1);
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    @(posedge clk);
    #1 tx_valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [15:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (!tx_ready_b && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("push_b_ready", 32'(tx_ready_b), 32'h1);
    tx_data_b  = d;
    tx_valid_b = 1'b1;
    @(posedge clk);
    #1 tx_valid_b = 1'b0;
  endtask

  // Mode-0 master for instance A. Bits come from mw[15] downwards. A whole
  // number of words ends with the final sclk fall and cs rise together; a
  // partial frame raises cs half a period after the last fall. hs_last raises
  // rx_ready for exactly the clk edge on which the final bit completes.
  task automatic frame8(input logic [15:0] mw, input int nbits, input bit hs_last,
                        output logic [15:0] mi);
    mi   = '0;
    cs_a = 1'b0;
    half();
    half();
    for (int i = 0; i < nbits; i++) begin
      mosi_a = mw[15-i];
      half();
      mi[15-i] = miso_a;
      sclk_a   = 1'b1;
      if (hs_last && i == nbits - 1) begin
        @(posedge clk);
        @(posedge clk);
        #1 rx_ready_a = 1'b1;
        @(posedge clk);
        #1 rx_ready_a = 1'b0;
      end
      half();
      sclk_a = 1'b0;
      if (i == nbits - 1 && (nbits % 8) == 0) cs_a = 1'b1;
    end
    if ((nbits % 8) != 0) begin
      half();
      cs_a = 1'b1;
    end
    mosi_a = 1'b0;
    half();
    half();
    half();
  endtask

  // Mode-3 LSB-first master for instance B: data out on fall, sample on rise.
  task automatic frame16(input logic [15:0] mw, output logic [15:0] mi);
    mi   = '0;
    cs_b = 1'b0;
    half();
    half();
    for (int i = 0; i < 16; i++) begin
      sclk_b = 1'b0;
      mosi_b = mw[i];
      half();
      mi[i]  = miso_b;
      sclk_b = 1'b1;
      half();
    end
    cs_b   = 1'b1;
    mosi_b = 1'b0;
    half();
    half();
    half();
  endtask

  typedef struct {
    logic [7:0] mosi;
    bit         has_tx;
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_und;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] mi;
    int u0, f0, o0;

    vecs[0] = '{8'hAA, 1'b0, 8'h00, 8'hAA, 8'h00, 1};
    vecs[1] = '{8'h55, 1'b1, 8'h3C, 8'h55, 8'h3C, 0};
    vecs[2] = '{8'h00, 1'b1, 8'hFF, 8'h00, 8'hFF, 0};
    vecs[3] = '{8'hFF, 1'b0, 8'h00, 8'hFF, 8'h00, 1};
    vecs[4] = '{8'h81, 1'b1, 8'h7E, 8'h81, 8'h7E, 0};
    vecs[5] = '{8'hC3, 1'b1, 8'h96, 8'hC3, 8'h96, 0};

    rst        = 1'b1;
    sclk_a     = 1'b0; cs_a = 1'b1; mosi_a = 1'b0;
    rx_ready_a = 1'b1; tx_valid_a = 1'b0; tx_data_a = '0;
    sclk_b     = 1'b1; cs_b = 1'b1; mosi_b = 1'b0;
    rx_ready_b = 1'b1; tx_valid_b = 1'b0; tx_data_b = '0;

    repeat (4) @(negedge clk);
    chk("rst_rx_valid", 32'(rx_valid_a), 32'h0);
    chk("rst_busy",     32'(busy_a),     32'h0);
    chk("rst_ferr",     32'(ferr_a),     32'h0);
    chk("rst_ovr",      32'(ovr_a),      32'h0);
    chk("rst_und",      32'(und_a),      32'h0);
    chk("rst_miso",     32'(miso_a),     32'h0);
    chk("rst_tx_ready", 32'(tx_ready_a), 32'h1);
    chk("rst_rx_data",  32'(rx_data_a),  32'h0);
    chk("rst_b_ready",  32'(tx_ready_b), 32'h1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 32'(busy_a), 32'h0);

    // Single-word mode-0 frames
    for (int k = 0; k < 6; k++) begin
      u0 = n_und_a;
      f0 = n_ferr_a;
      q_a.delete();
      if (vecs[k].has_tx) push_a(vecs[k].tx);
      frame8({vecs[k].mosi, 8'h00}, 8, 1'b0, mi);
      chk($sformatf("v%0d_rx_count", k), 32'(q_a.size()), 32'h1);
      chk($sformatf("v%0d_rx_word", k), qa_at(0), 32'(vecs[k].exp_rx));
      chk($sformatf("v%0d_miso", k), 32'(mi[15:8]), 32'(vecs[k].exp_miso));
      chk($sformatf("v%0d_underrun", k), 32'(n_und_a - u0), 32'(vecs[k].exp_und));
      chk($sformatf("v%0d_frame_err", k), 32'(n_ferr_a - f0), 32'h0);
      chk($sformatf("v%0d_busy_idle", k), 32'(busy_a), 32'h0);
      chk($sformatf("v%0d_miso_idle", k), 32'(miso_a), 32'h0);
    end

    // Two words back-to-back under one cs, second tx word queued mid-frame
    u0 = n_und_a;
    q_a.delete();
    push_a(8'h5A);
    fork
      push_a(8'hC3);
      frame8(16'h33FF, 16, 1'b0, mi);
    join
    chk("multi_rx_count", 32'(q_a.size()), 32'h2);
    chk("multi_rx_w0", qa_at(0), 32'h33);
    chk("multi_rx_w1", qa_at(1), 32'hFF);
    chk("multi_miso", 32'(mi), 32'h5AC3);
    chk("multi_underrun", 32'(n_und_a - u0), 32'h0);

    // Aborted frame after 3 bits, then a clean 0x00 frame
    f0 = n_ferr_a;
    q_a.delete();
    frame8(16'hE000, 3, 1'b0, mi);
    chk("abort_ferr", 32'(n_ferr_a - f0), 32'h1);
    chk("abort_rx_count", 32'(q_a.size()), 32'h0);
    chk("abort_rx_valid", 32'(rx_valid_a), 32'h0);
    q_a.delete();
    frame8(16'h0000, 8, 1'b0, mi);
    chk("after_abort_count", 32'(q_a.size()), 32'h1);
    chk("after_abort_word", qa_at(0), 32'h00);
    chk("after_abort_rx_data", 32'(rx_data_a), 32'h00);
    chk("after_abort_ferr", 32'(n_ferr_a - f0), 32'h1);

    // Overrun: two words with rx_ready low
    rx_ready_a = 1'b0;
    o0 = n_ovr_a;
    frame8(16'h1122, 16, 1'b0, mi);
    chk("ovr_pulse", 32'(n_ovr_a - o0), 32'h1);
    chk("ovr_rx_data", 32'(rx_data_a), 32'h22);
    chk("ovr_rx_valid", 32'(rx_valid_a), 32'h1);
    // Handshake on the very cycle the next word completes
    o0 = n_ovr_a;
    frame8(16'h4400, 8, 1'b1, mi);
    chk("hs_same_cycle_ovr", 32'(n_ovr_a - o0), 32'h0);
    chk("hs_same_cycle_valid", 32'(rx_valid_a), 32'h1);
    chk("hs_same_cycle_data", 32'(rx_data_a), 32'h44);
    rx_ready_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("drain_rx_valid", 32'(rx_valid_a), 32'h0);

    // Instance B: 16-bit, CPOL=1, CPHA=1, LSB first
    u0 = n_und_b;
    q_b.delete();
    push_b(16'h1234);
    frame16(16'hBEEF, mi);
    chk("b_rx_count", 32'(q_b.size()), 32'h1);
    chk("b_rx_word", qb_at(0), 32'hBEEF);
    chk("b_miso", 32'(mi), 32'h1234);
    chk("b_underrun", 32'(n_und_b - u0), 32'h0);
    u0 = n_und_b;
    q_b.delete();
    frame16(16'h8001, mi);
    chk("b2_rx_word", qb_at(0), 32'h8001);
    chk("b2_miso", 32'(mi), 32'h0000);
    chk("b2_underrun", 32'(n_und_b - u0), 32'h1);
    chk("b_ferr", 32'(n_ferr_b), 32'h0);

    // Reset mid-frame after 4 bits, then a full 0xA5 frame
    f0 = n_ferr_a;
    cs_a = 1'b0;
    half();
    half();
    for (int i = 0; i < 4; i++) begin
      mosi_a = 1'b1;
      half();
      sclk_a = 1'b1;
      half();
      sclk_a = 1'b0;
    end
    half();
    chk("midframe_busy", 32'(busy_a), 32'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("in_rst_busy", 32'(busy_a), 32'h0);
    chk("in_rst_rx_valid", 32'(rx_valid_a), 32'h0);
    chk("in_rst_tx_ready", 32'(tx_ready_a), 32'h1);
    chk("in_rst_ferr", 32'(ferr_a), 32'h0);
    cs_a   = 1'b1;
    mosi_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    half();
    half();
    q_a.delete();
    frame8(16'hA500, 8, 1'b0, mi);
    chk("rst_recover_count", 32'(q_a.size()), 32'h1);
    chk("rst_recover_word", qa_at(0), 32'hA5);
    chk("rst_recover_ferr", 32'(n_ferr_a - f0), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
